// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU and RV64 *W forms).
// One operation in flight; valid/ready on both sides; flush aborts the operation.
module div_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            sel_rem_q, sel_rem_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] res_q, res_d;

  // Bits above 31 become bit 31 (sgn) or zero; no-op unless w is set.
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v,
                                             input logic w, input logic sgn);
    logic [XLEN-1:0] r;
    r = v;
    if (w) begin
      for (int unsigned i = 32; i < XLEN; i++) r[i] = sgn & v[31];
    end
    return r;
  endfunction

  logic            wop, s1, s2, div_zero, ovf;
  logic [XLEN-1:0] op1, op2, a1, a2, minv, sp_res;
  logic [XLEN:0]   rem_sh, diff, rem_nx;
  logic            qbit;
  logic [XLEN-1:0] quo_nx, q_fin, r_fin, fin;

  always_comb begin
    wop      = (XLEN == 64) && is_word;
    op1      = ext32(src1, wop, is_signed);
    op2      = ext32(src2, wop, is_signed);
    s1       = is_signed & op1[XLEN-1];
    s2       = is_signed & op2[XLEN-1];
    a1       = s1 ? -op1 : op1;
    a2       = s2 ? -op2 : op2;
    minv     = '0;
    if (wop) begin
      minv[31] = 1'b1;
      minv     = ext32(minv, 1'b1, 1'b1);
    end else begin
      minv[XLEN-1] = 1'b1;
    end
    div_zero = (op2 == '0);
    ovf      = is_signed && (op2 == '1) && (op1 == minv);
    if (is_rem) sp_res = div_zero ? op1 : '0;
    else        sp_res = div_zero ? '1 : op1;
    sp_res   = ext32(sp_res, wop, 1'b1);
  end

  // Partial remainder is always below the divisor, so the shifted value fits
  // in XLEN+1 bits and the top bit of the difference is a true borrow.
  always_comb begin
    rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    qbit   = ~diff[XLEN];
    rem_nx = qbit ? diff : rem_sh;
    quo_nx = {quo_q[XLEN-2:0], qbit};
    q_fin  = negq_q ? -quo_nx : quo_nx;
    r_fin  = negr_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
    fin    = ext32(sel_rem_q ? r_fin : q_fin, word_q, 1'b1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    sel_rem_d = sel_rem_q;
    word_d    = word_q;
    res_d     = res_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (div_zero || ovf) begin
              res_d   = sp_res;
              state_d = DONE;
            end else begin
              // Word dividends are left-aligned so the MSB-first shift works
              // unchanged; the quotient then lands in the low 32 bits.
              rem_d     = '0;
              quo_d     = wop ? (a1 << (XLEN - 32)) : a1;
              dvs_d     = a2;
              negq_d    = s1 ^ s2;
              negr_d    = s1;
              sel_rem_d = is_rem;
              word_d    = wop;
              cnt_d     = wop ? CW'(31) : CW'(XLEN - 1);
              state_d   = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == '0) begin
            res_d   = fin;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      sel_rem_q <= 1'b0;
      word_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      sel_rem_q <= sel_rem_d;
      word_q    <= word_d;
      res_q     <= res_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result_out = res_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter (XLEN=64): directed vectors, abort/reset and
// randomized ops checked against an arithmetic reference model.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [63:0] src1, src2, result_out;
  logic        is_signed, is_rem, is_word;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  div_iter #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2),
    .is_signed(is_signed), .is_rem(is_rem), .is_word(is_word),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic sg, input logic rm, input logic wd);
    logic [63:0] r;
    if (wd) begin
      logic [31:0] a32, b32, r32;
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0)                                     r32 = rm ? a32 : 32'hFFFF_FFFF;
      else if (sg && a32 == 32'h8000_0000 && b32 == '1)     r32 = rm ? 32'd0 : a32;
      else if (sg) r32 = rm ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else         r32 = rm ? a32 % b32 : a32 / b32;
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0)                                             r = rm ? a : '1;
      else if (sg && a == 64'h8000_0000_0000_0000 && b == '1)     r = rm ? 64'd0 : a;
      else if (sg) r = rm ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
      else         r = rm ? a % b : a / b;
    end
    return r;
  endfunction

  task automatic start(input logic [63:0] a, input logic [63:0] b, input logic sg,
                       input logic rm, input logic wd, input logic [63:0] exp);
    @(negedge clk);
    check_eq("in_ready_before_req", {63'd0, in_ready}, 64'd1);
    src1 = a; src2 = b; is_signed = sg; is_rem = rm; is_word = wd;
    in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = 'x; src2 = 'x;
  endtask

  task automatic wait_out(input int lat, input string tag);
    int cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
      if (sb.size() == 0) check_eq({tag, "_sb_empty"}, 64'd0, 64'd1);
      else                check_eq(tag, result_out, sb.pop_front());
    end
  endtask

  task automatic handoff(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_idle_ready"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic sg,
                     input logic rm, input logic wd, input logic [63:0] exp,
                     input int lat, input string tag);
    start(a, b, sg, rm, wd, exp);
    wait_out(lat, tag);
    handoff(tag);
  endtask

  initial begin
    logic [63:0] a, b;
    logic        sg, rm, wd, spec;
    int          lat;
    logic        seen;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_flags", {62'd0, in_ready, out_valid}, 64'b10);
    check_eq("reset_result", result_out, 64'd0);

    run(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2");
    run(-64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_m7_2");
    run(64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_by0");
    run(64'h1234, 64'd0, 1'b0, 1'b1, 1'b0, 64'h1234, 1, "remu_by0");
    run(64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
    run(64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 64'd0, 1, "remw_ovf");
    run(64'hDEAD_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33, "divuw");
    run(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1, "div_ovf64");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 65, "divu_max_3");
    run(64'd5, 64'd0, 1'b0, 1'b1, 1'b1, 64'd5, 1, "remuw_by0");

    // Backpressure: result held, in_ready low while out_ready=0
    out_ready = 1'b0;
    start(64'd1000, 64'd7, 1'b0, 1'b0, 1'b0, 64'd142);
    wait_out(65, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_flags", {62'd0, in_ready, out_valid}, 64'b01);
      check_eq("bp_hold_result", result_out, 64'd142);
    end
    out_ready = 1'b1;
    handoff("bp");

    // Flush mid-CALC
    start(64'd1000, 64'd7, 1'b0, 1'b0, 1'b0, 64'd142);
    repeat (19) begin @(posedge clk); #1; end
    check_eq("calc_busy", {62'd0, in_ready, out_valid}, 64'b00);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_idle", {62'd0, in_ready, out_valid}, 64'b10);
    sb.delete();
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check_eq("flush_no_out", {63'd0, seen}, 64'd0);

    // Request coincident with flush in IDLE is not accepted
    @(negedge clk);
    src1 = 64'd9; src2 = 64'd0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_blocks_accept", {62'd0, in_ready, out_valid}, 64'b10);

    // Reset while in DONE
    out_ready = 1'b0;
    start(64'h77, 64'd0, 1'b0, 1'b1, 1'b0, 64'h77);
    wait_out(1, "pre_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check_eq("rst_done_flags", {62'd0, in_ready, out_valid}, 64'b10);
    check_eq("rst_done_result", result_out, 64'd0);
    run(64'd100, 64'd7, 1'b1, 1'b0, 1'b0, 64'd14, 65, "post_rst_q");
    run(64'd100, 64'd7, 1'b1, 1'b1, 1'b0, 64'd2, 65, "post_rst_r");

    // Randomized ops against the reference model
    for (int i = 0; i < 24; i++) begin
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 2) == 0) ? 64'($signed(32'($urandom_range(0, 20)) - 32'sd10))
                                        : {$urandom, $urandom} >> $urandom_range(0, 60);
      sg = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      if (wd) spec = (b[31:0] == 32'd0) || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
      else    spec = (b == 64'd0) || (sg && a == 64'h8000_0000_0000_0000 && b == '1);
      lat = spec ? 1 : (wd ? 33 : 65);
      run(a, b, sg, rm, wd, ref_div(a, b, sg, rm, wd), lat, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
